// File: rtl/dmem_sram_responder.sv
// Data-side SRAM responder: one outstanding load/store, byte-lane stores, bus error on bad requests.
// Latency: data_ok exactly LATENCY cycles after the accept cycle; the next request may be accepted in the response cycle.
// Backpressure: addr_ok low while a response is pending (and during rst); req is ignored while addr_ok=0.
module dmem_sram_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        resp_err
);

   localparam int unsigned IW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     mem [DEPTH_WORDS];
   logic            pend_wr_q;
   logic            pend_err_q;
   logic [31:0]     pend_word_q;
   logic [31:0]     rdata_q;
   logic [31:0]     offset;
   logic [IW-1:0]   idx;
   logic            req_bad;
   logic            accept;

   // Offset from the window base; addresses below BASE_ADDR wrap high and fail the range test.
   assign offset = addr - BASE_ADDR;
   assign idx    = offset[IW+1:2];

   // Classify the request: range, size/strobe consistency and natural alignment.
   always_comb begin
      req_bad = (offset >= SPAN);
      case (size)
         2'd0:    if ($countones(sel) != 1) req_bad = 1'b1;
         2'd1:    if (!(sel == 4'b0011 || sel == 4'b1100) || addr[0]) req_bad = 1'b1;
         2'd2:    if (sel != 4'b1111 || addr[1:0] != 2'b00) req_bad = 1'b1;
         default: req_bad = 1'b1;
      endcase
   end

   assign data_ok  = (state_q == WAIT) && (cnt_q == 4'd0);
   assign addr_ok  = !rst && ((state_q == IDLE) || data_ok);
   assign accept   = req && addr_ok;
   assign resp_err = data_ok && pend_err_q;
   // Load data is visible during the data_ok cycle and held afterwards until the next load response.
   assign rdata    = (data_ok && !pend_wr_q) ? pend_word_q : rdata_q;

   // Next-state: start the latency countdown on accept, reload it when a request lands in the response cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (accept) begin
               cnt_d = 4'(LATENCY - 1);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State register; reset drops any pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the response at accept and retire load data into the holding register at the response edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q     <= 32'd0;
         pend_wr_q   <= 1'b0;
         pend_err_q  <= 1'b0;
         pend_word_q <= 32'd0;
      end else begin
         if (data_ok && !pend_wr_q) rdata_q <= pend_word_q;
         if (accept) begin
            pend_wr_q   <= wr;
            pend_err_q  <= req_bad;
            pend_word_q <= req_bad ? 32'd0 : mem[idx];
         end
      end
   end

   // Word array: stores commit at their own accept edge, selected lanes only; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && wr && !req_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: three instances (LATENCY 2/1/15) against a transaction-level reference.
// Latency: the reference predicts each response cycle as accept cycle + LATENCY.
// Backpressure: the reference decides acceptance from its own notion of an outstanding request.
module tb_dmem_sram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s   [3];
   logic        req_s   [3];
   logic        wr_s    [3];
   logic [1:0]  size_s  [3];
   logic [3:0]  sel_s   [3];
   logic [31:0] addr_s  [3];
   logic [31:0] wdata_s [3];
   logic        aok_s   [3];
   logic        dok_s   [3];
   logic [31:0] rdata_s [3];
   logic        err_s   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_sram_responder #(
         .DEPTH_WORDS (64),
         .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 15)),
         .BASE_ADDR   (g == 1 ? 32'h0000_0400 : 32'h0000_0000)
      ) u_dut (
         .clk      (clk),
         .rst      (rst_s[g]),
         .req      (req_s[g]),
         .wr       (wr_s[g]),
         .size     (size_s[g]),
         .sel      (sel_s[g]),
         .addr     (addr_s[g]),
         .wdata    (wdata_s[g]),
         .addr_ok  (aok_s[g]),
         .data_ok  (dok_s[g]),
         .rdata    (rdata_s[g]),
         .resp_err (err_s[g])
      );
   end

   function automatic int lat_of(int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
   endfunction

   function automatic logic [31:0] base_of(int k);
      return (k == 1) ? 32'h0000_0400 : 32'h0000_0000;
   endfunction

   // Reference rules for a bad request, straight from the error list.
   function automatic logic is_bad(int k, logic [1:0] sz, logic [3:0] sl, logic [31:0] a);
      logic [31:0] off;
      logic bad;
      off = a - base_of(k);
      bad = (off >= 32'd256);
      if (sz == 2'd3) bad = 1'b1;
      if (sz == 2'd0 && $countones(sl) != 1) bad = 1'b1;
      if (sz == 2'd1 && (!(sl == 4'b0011 || sl == 4'b1100) || a[0])) bad = 1'b1;
      if (sz == 2'd2 && (sl != 4'b1111 || a[1:0] != 2'b00)) bad = 1'b1;
      return bad;
   endfunction

   function automatic int word_of(int k, logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(k);
      return int'(off[7:2]);
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] sl);
      logic [31:0] w;
      w = old;
      for (int i = 0; i < 4; i++) if (sl[i]) w[8*i +: 8] = d[8*i +: 8];
      return w;
   endfunction

   // Reference state
   logic [31:0] mem_m  [3][64];
   int          due    [3] = '{-1, -1, -1};
   logic        p_wr   [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] p_word [3] = '{32'd0, 32'd0, 32'd0};
   logic        p_err  [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] held   [3] = '{32'd0, 32'd0, 32'd0};
   logic        acc    [3] = '{1'b0, 1'b0, 1'b0};
   int          cyc    = 0;
   logic        mon_en = 1'b0;
   int          nvec   = 0;
   int          nerr   = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: at each edge retire a due load, then accept if nothing is outstanding past this cycle.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_s[k]) begin
            due[k]  <= -1;
            held[k] <= 32'd0;
            acc[k]  <= 1'b0;
         end else begin
            if (cyc == due[k] && !p_wr[k]) held[k] <= p_word[k];
            if (req_s[k] && due[k] <= cyc) begin
               acc[k]    <= 1'b1;
               due[k]    <= cyc + lat_of(k);
               p_wr[k]   <= wr_s[k];
               p_err[k]  <= is_bad(k, size_s[k], sel_s[k], addr_s[k]);
               p_word[k] <= is_bad(k, size_s[k], sel_s[k], addr_s[k]) ? 32'd0
                            : mem_m[k][word_of(k, addr_s[k])];
               if (wr_s[k] && !is_bad(k, size_s[k], sel_s[k], addr_s[k]))
                  mem_m[k][word_of(k, addr_s[k])] <=
                     merge(mem_m[k][word_of(k, addr_s[k])], wdata_s[k], sel_s[k]);
            end else begin
               acc[k] <= 1'b0;
            end
         end
      end
      cyc <= cyc + 1;
   end

   // Every cycle compare all outputs of all instances against the reference.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            logic e_dok;
            e_dok = (cyc == due[k]);
            chk($sformatf("i%0d_data_ok", k), 32'(dok_s[k]), 32'(e_dok));
            chk($sformatf("i%0d_addr_ok", k), 32'(aok_s[k]), 32'(!rst_s[k] && due[k] <= cyc));
            chk($sformatf("i%0d_resp_err", k), 32'(err_s[k]), 32'(e_dok && p_err[k]));
            chk($sformatf("i%0d_rdata", k), rdata_s[k],
                (e_dok && !p_wr[k]) ? p_word[k] : held[k]);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(int k, logic w, logic [1:0] sz, logic [3:0] sl,
                        logic [31:0] a, logic [31:0] d, logic hold);
      int n;
      n = 0;
      wr_s[k] = w; size_s[k] = sz; sel_s[k] = sl; addr_s[k] = a; wdata_s[k] = d;
      req_s[k] = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!acc[k] && n < 40);
      chk($sformatf("i%0d_accept", k), 32'(acc[k]), 32'd1);
      if (!hold) req_s[k] = 1'b0;
   endtask

   task automatic rand_fields(int k);
      int r, off;
      logic [1:0] sz;
      logic [3:0] sl;
      logic [31:0] a;
      r  = int'($urandom % 8);
      sz = (r < 3) ? 2'd0 : ((r < 5) ? 2'd1 : ((r < 7) ? 2'd2 : 2'd3));
      a  = base_of(k) + 32'(($urandom % 64) * 4);
      case (sz)
         2'd0: begin off = int'($urandom % 4); sl = 4'b0001 << off; a = a + 32'(off); end
         2'd1: begin
            if ($urandom % 2 == 1) begin sl = 4'b1100; a = a + 32'd2; end
            else sl = 4'b0011;
         end
         2'd2: sl = 4'b1111;
         default: sl = 4'($urandom);
      endcase
      r = int'($urandom % 16);
      if (r == 0) sl = 4'($urandom);
      else if (r == 1) a[1:0] = 2'($urandom);
      else if (r == 2) a = base_of(k) + 32'd256 + 32'(($urandom % 8) * 4);
      else if (r == 3) a = base_of(k) - 32'd4;
      wr_s[k] = 1'($urandom); size_s[k] = sz; sel_s[k] = sl; addr_s[k] = a;
      wdata_s[k] = $urandom;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      for (int k = 0; k < 3; k++) begin
         rst_s[k] = 1'b1; req_s[k] = 1'b0; wr_s[k] = 1'b0; size_s[k] = 2'd0;
         sel_s[k] = 4'd0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
      end
      tick(1);
      mon_en = 1'b1;
      tick(2);
      for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;

      // Give every word a known value so later loads are predictable.
      for (int k = 0; k < 3; k++)
         for (int w = 0; w < 64; w++)
            issue(k, 1'b1, 2'd2, 4'hF, base_of(k) + 32'(w * 4), $urandom, 1'b0);
      tick(20);

      // Word store, with the response latency measured explicitly.
      issue(0, 1'b1, 2'd2, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!dok_s[0] && n < 20);
      chk("lat2_store", 32'(n), 32'd2);
      chk("store_err", 32'(err_s[0]), 32'd0);
      tick(2);
      issue(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'd0, 1'b0); tick(3);
      chk("load_word", rdata_s[0], 32'hDEAD_BEEF);

      // Byte lane merge
      issue(0, 1'b1, 2'd0, 4'b0100, 32'h10, 32'h00AB_0000, 1'b0); tick(3);
      issue(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'd0, 1'b0); tick(3);
      chk("load_byte_merge", rdata_s[0], 32'hDEAB_BEEF);

      // Misaligned word load and out-of-window store
      issue(0, 1'b0, 2'd2, 4'hF, 32'h12, 32'd0, 1'b0); tick(3);
      chk("misaligned_rdata", rdata_s[0], 32'd0);
      issue(0, 1'b1, 2'd2, 4'hF, 32'h100, 32'h5555_5555, 1'b0); tick(3);
      issue(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'd0, 1'b0); tick(3);
      chk("oob_store_dropped", rdata_s[0], mem_m[0][0]);

      // Reset in the WAIT cycle before data_ok
      issue(0, 1'b1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 1'b0); tick(3);
      issue(0, 1'b0, 2'd2, 4'hF, 32'h24, 32'd0, 1'b0);
      rst_s[0] = 1'b1;
      tick(1);
      rst_s[0] = 1'b0;
      @(negedge clk);
      chk("rst_no_data_ok", 32'(dok_s[0]), 32'd0);
      chk("rst_addr_ok", 32'(aok_s[0]), 32'd1);
      tick(1);
      issue(0, 1'b0, 2'd2, 4'hF, 32'h20, 32'd0, 1'b0); tick(3);
      chk("store_survives_rst", rdata_s[0], 32'h1234_5678);

      // LATENCY=1 back-to-back loads with req held high
      for (int i = 0; i < 4; i++)
         issue(1, 1'b0, 2'd2, 4'hF, 32'h400 + 32'(i * 4), 32'd0, 1'b1);
      req_s[1] = 1'b0;
      tick(3);

      // LATENCY=15 with req held high throughout
      repeat (100) begin rand_fields(2); req_s[2] = 1'b1; tick(1); end
      req_s[2] = 1'b0;
      tick(20);

      // Randomized traffic on every instance
      for (int k = 0; k < 3; k++) begin
         repeat (400) begin
            rand_fields(k);
            req_s[k] = ($urandom % 4 != 0);
            tick(1);
         end
         req_s[k] = 1'b0;
         tick(20);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_sram_responder.md
Name: dmem_sram_responder

Overview:
- Data-side SRAM-like responder: the slave end of the load/store interface the memory stage drives (byte strobes, size, aligned address, write data).
- Accepts one request at a time with an addr_ok/data_ok handshake, services it from an internal word array after a fixed programmable latency, and returns read data or a bus error.
- Used as the simulation and FPGA data memory behind the memory stage, and as the reference slave for verifying the stage's request generation.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, cycles from the accept edge to the data_ok cycle (legal range 1..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  1  request valid from the initiator.
- wr  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- sel  input  4  byte strobes; sel[i] covers bits 8i+7:8i.
- addr  input  32  byte address.
- wdata  input  32  store data, already lane-aligned by the initiator.
- addr_ok  output  1  request accepted this cycle when req=1.
- data_ok  output  1  one-cycle response pulse.
- rdata  output  32  load data, full word; valid when data_ok=1 for a load.
- resp_err  output  1  error qualifier, valid with data_ok.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0, data_ok=0, resp_err=0, rdata=0.
  - Any pending response is discarded and never issued.
  - The array is not cleared.
- States: IDLE and WAIT.
- addr_ok is combinational. It is 1 in IDLE, and 1 in WAIT during the data_ok cycle. It is 0 otherwise and 0 while rst=1.
- Accept occurs in a cycle where req=1 and addr_ok=1. The bank captures wr, the error flag and the computed read word, loads counter=LATENCY-1 and moves to WAIT.
- In WAIT, counter decrements each cycle. data_ok=1 (combinational from state) in the cycle where counter==0.
- Response cycle:
  - If no new accept occurs, the next state is IDLE.
  - If a new accept occurs in the same cycle, the bank stays in WAIT and reloads the counter. Peak throughput is one request per LATENCY cycles.
- Latency: data_ok rises exactly LATENCY cycles after the accept cycle. With LATENCY=1, data_ok is in the cycle immediately after accept.
- Error conditions, evaluated at accept:
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  - size=3.
  - size=0 and sel is not one-hot.
  - size=1 and sel is not 4'b0011 or 4'b1100.
  - size=2 and sel is not 4'b1111.
  - size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
- On error: the store is dropped, a load returns rdata=0, and resp_err=1 with data_ok.
- Index: (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Commit on the accept edge, byte lanes per sel only. Unselected lanes keep their old value.
  - rdata is unchanged by a store response.
- Loads:
  - The word is read at the accept edge and the full word is returned.
  - A load accepted after a store to the same word sees the new data, because the store committed at its own accept edge.
  - rdata is registered at the response edge and holds until the next load response.
- Ordering: responses are strictly in acceptance order; at most one request is outstanding.
- Initiator contract: req/addr/wdata/sel/size/wr must be stable only in the accept cycle. The bank ignores req while addr_ok=0.
- rst asserted mid-WAIT:
  - The next cycle is IDLE with no data_ok.
  - A store accepted before reset remains committed.

Test Plan:
- Reset, then word store addr=0x10, sel=1111, wdata=0xDEADBEEF, LATENCY=2 → data_ok exactly 2 cycles after accept, resp_err=0. Load 0x10 → rdata=0xDEADBEEF.
- Byte store sel=0100, wdata=0x00AB0000 to 0x10, then load 0x10 → rdata=0xDEABBEEF.
- Back-to-back: req held high for 4 loads with LATENCY=1 → one data_ok per cycle after the first, and addr_ok=1 each response cycle.
- Load size=2 at addr=0x12 → data_ok with resp_err=1, rdata=0. Store addr=BASE_ADDR+DEPTH_WORDS*4 → resp_err=1 and array unchanged.
- rst pulsed in the WAIT cycle before data_ok → no data_ok appears, addr_ok=1 the cycle after reset, and an earlier committed store is still readable.
- LATENCY=15 with req held high throughout → addr_ok=0 for 14 cycles, and exactly one accept per response.
